// File: rtl/ace_snoop_pkg.sv
// Shared definitions for the ACE snoop sequencer: FSM state encoding, engine trigger code
// and the CR response bit layout.
package ace_snoop_pkg;

    localparam logic [3:0] DEVIL_EN_CODE = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DISPATCH = 3'd1,
        ST_WAIT     = 3'd2,
        ST_DEV_CR   = 3'd3,
        ST_DEV_CD   = 3'd4,
        ST_DEF_CR   = 3'd5,
        ST_RELEASE  = 3'd6
    } seq_state_e;

    // Bit 0 is DataTransfer, bit 4 is WasUnique.
    typedef struct packed {
        logic was_unique;
        logic is_shared;
        logic pass_dirty;
        logic error;
        logic data_transfer;
    } crresp_t;

    localparam crresp_t CRRESP_DEFAULT = '0;

    function automatic logic crresp_has_data(input logic [4:0] resp);
        crresp_t r;
        r = crresp_t'(resp);
        return r.data_transfer;
    endfunction

endpackage

// File: rtl/snoop_sat_counter.sv
// Status counter that increments on i_inc and sticks at all-ones.
module snoop_sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/ace_snoop_sequencer.sv
// ACE AC/CR/CD snoop front end for the devil engine: one snoop at a time, real AXI handshakes,
// benign default response when the engine declines or stalls.
//   IDLE     | waiting for acvalid          DISPATCH | trigger pulse to engine
//   WAIT     | waiting for engine verdict   DEV_CR   | engine CR    DEV_CD | engine data beats
//   DEF_CR   | default CR, no data          RELEASE  | wait for engine to return to IDLE
module ace_snoop_sequencer
    import ace_snoop_pkg::*;
#(
    parameter int         C_ACE_ADDR_WIDTH = 44,
    parameter int         C_ACE_DATA_WIDTH = 128,
    parameter int         CD_BEATS         = 4,
    parameter logic [3:0] DEVIL_EN         = DEVIL_EN_CODE,
    parameter int         CNT_WIDTH        = 32
) (
    input  logic                        ace_aclk,
    input  logic                        ace_aresetn,
    input  logic                        acvalid,
    output logic                        acready,
    input  logic [3:0]                  acsnoop,
    input  logic [C_ACE_ADDR_WIDTH-1:0] acaddr,
    output logic                        crvalid,
    input  logic                        crready,
    output logic [4:0]                  crresp,
    output logic                        cdvalid,
    input  logic                        cdready,
    output logic [C_ACE_DATA_WIDTH-1:0] cddata,
    output logic                        cdlast,
    output logic [3:0]                  o_snoop_state,
    output logic [3:0]                  o_acsnoop,
    output logic [C_ACE_ADDR_WIDTH-1:0] o_acaddr,
    input  logic [3:0]                  i_devil_state,
    input  logic                        i_devil_crvalid,
    input  logic                        i_devil_cdvalid,
    input  logic                        i_devil_cdlast,
    input  logic [4:0]                  i_devil_crresp,
    input  logic [C_ACE_DATA_WIDTH-1:0] i_devil_rdata,
    input  logic                        i_en,
    input  logic [15:0]                 i_timeout,
    output logic [CNT_WIDTH-1:0]        o_cnt_snoop,
    output logic [CNT_WIDTH-1:0]        o_cnt_devil,
    output logic [CNT_WIDTH-1:0]        o_cnt_default,
    output logic [CNT_WIDTH-1:0]        o_cnt_timeout
);

    localparam int BEAT_W = (CD_BEATS > 1) ? $clog2(CD_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(CD_BEATS - 1);

    seq_state_e                  r_state;
    logic                        r_acready;
    logic [3:0]                  r_acsnoop;
    logic [C_ACE_ADDR_WIDTH-1:0] r_acaddr;
    logic [3:0]                  r_snoop_state;
    logic                        r_crvalid;
    logic [4:0]                  r_crresp;
    logic                        r_cdvalid;
    logic [C_ACE_DATA_WIDTH-1:0] r_cddata;
    logic                        r_cdlast;
    logic [BEAT_W-1:0]           r_beat;
    logic [15:0]                 r_wait_cnt;
    logic                        r_seen_busy;
    logic                        r_dispatched;

    logic        w_wait_hit;
    logic        w_declined;
    logic        w_last_beat;
    logic [15:0] w_wait_inc;
    logic        w_inc_snoop;
    logic        w_inc_devil;
    logic        w_inc_default;
    logic        w_inc_timeout;

    assign w_wait_hit  = (i_timeout != 16'd0) && (r_wait_cnt == (i_timeout - 16'd1));
    assign w_declined  = r_seen_busy && (i_devil_state == 4'd0);
    assign w_last_beat = (r_beat == LAST_BEAT);
    assign w_wait_inc  = (r_wait_cnt == 16'hFFFF) ? r_wait_cnt : r_wait_cnt + 16'd1;

    assign w_inc_snoop   = (r_state == ST_IDLE) && acvalid;
    assign w_inc_devil   = (r_state == ST_WAIT) && i_devil_crvalid;
    assign w_inc_timeout = (r_state == ST_WAIT) && !i_devil_crvalid && !w_declined && w_wait_hit;
    assign w_inc_default = (r_state == ST_DEF_CR) && crready;

    always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
        if (!ace_aresetn) begin
            r_state       <= ST_IDLE;
            r_acready     <= 1'b0;
            r_acsnoop     <= '0;
            r_acaddr      <= '0;
            r_snoop_state <= '0;
            r_crvalid     <= 1'b0;
            r_crresp      <= '0;
            r_cdvalid     <= 1'b0;
            r_cddata      <= '0;
            r_cdlast      <= 1'b0;
            r_beat        <= '0;
            r_wait_cnt    <= '0;
            r_seen_busy   <= 1'b0;
            r_dispatched  <= 1'b0;
        end else begin
            r_acready     <= 1'b0;
            r_snoop_state <= '0;
            case (r_state)
                ST_IDLE: begin
                    r_dispatched <= 1'b0;
                    if (acvalid) begin
                        r_acready <= 1'b1;
                        r_acsnoop <= acsnoop;
                        r_acaddr  <= acaddr;
                        if (i_en) begin
                            r_snoop_state <= DEVIL_EN;
                            r_state       <= ST_DISPATCH;
                        end else begin
                            r_crvalid <= 1'b1;
                            r_crresp  <= CRRESP_DEFAULT;
                            r_state   <= ST_DEF_CR;
                        end
                    end
                end
                ST_DISPATCH: begin
                    r_wait_cnt   <= '0;
                    r_seen_busy  <= 1'b0;
                    r_dispatched <= 1'b1;
                    r_state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_wait_cnt <= w_wait_inc;
                    if (i_devil_state != 4'd0) begin
                        r_seen_busy <= 1'b1;
                    end
                    if (i_devil_crvalid) begin
                        r_crvalid <= 1'b1;
                        r_crresp  <= i_devil_crresp;
                        r_state   <= ST_DEV_CR;
                    end else if (w_declined || w_wait_hit) begin
                        r_crvalid <= 1'b1;
                        r_crresp  <= CRRESP_DEFAULT;
                        r_state   <= ST_DEF_CR;
                    end
                end
                ST_DEV_CR: begin
                    if (crready) begin
                        r_crvalid  <= 1'b0;
                        r_beat     <= '0;
                        r_wait_cnt <= '0;
                        r_state    <= crresp_has_data(r_crresp) ? ST_DEV_CD : ST_RELEASE;
                    end
                end
                ST_DEV_CD: begin
                    if (r_cdvalid) begin
                        if (cdready) begin
                            r_cdvalid <= 1'b0;
                            r_cdlast  <= 1'b0;
                            if (w_last_beat) begin
                                r_wait_cnt <= '0;
                                r_state    <= ST_RELEASE;
                            end else begin
                                r_beat <= r_beat + 1'b1;
                            end
                        end
                    end else if (i_devil_cdvalid && (!w_last_beat || i_devil_cdlast)) begin
                        // final beat waits for the engine's cdlast, stretching it if late
                        r_cdvalid <= 1'b1;
                        r_cddata  <= i_devil_rdata;
                        r_cdlast  <= w_last_beat;
                    end
                end
                ST_DEF_CR: begin
                    if (crready) begin
                        r_crvalid  <= 1'b0;
                        r_wait_cnt <= '0;
                        // an engine that was triggered must settle before the next snoop
                        r_state    <= r_dispatched ? ST_RELEASE : ST_IDLE;
                    end
                end
                ST_RELEASE: begin
                    r_wait_cnt <= w_wait_inc;
                    if ((i_devil_state == 4'd0) || w_wait_hit) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign acready       = r_acready;
    assign o_acsnoop     = r_acsnoop;
    assign o_acaddr      = r_acaddr;
    assign o_snoop_state = r_snoop_state;
    assign crvalid       = r_crvalid;
    assign crresp        = r_crresp;
    assign cdvalid       = r_cdvalid;
    assign cddata        = r_cddata;
    assign cdlast        = r_cdlast;

    snoop_sat_counter #(.W(CNT_WIDTH)) u_cnt_snoop (
        .i_clk(ace_aclk), .i_rst_n(ace_aresetn), .i_inc(w_inc_snoop), .o_cnt(o_cnt_snoop)
    );
    snoop_sat_counter #(.W(CNT_WIDTH)) u_cnt_devil (
        .i_clk(ace_aclk), .i_rst_n(ace_aresetn), .i_inc(w_inc_devil), .o_cnt(o_cnt_devil)
    );
    snoop_sat_counter #(.W(CNT_WIDTH)) u_cnt_default (
        .i_clk(ace_aclk), .i_rst_n(ace_aresetn), .i_inc(w_inc_default), .o_cnt(o_cnt_default)
    );
    snoop_sat_counter #(.W(CNT_WIDTH)) u_cnt_timeout (
        .i_clk(ace_aclk), .i_rst_n(ace_aresetn), .i_inc(w_inc_timeout), .o_cnt(o_cnt_timeout)
    );

endmodule

// File: tb/tb_ace_snoop_sequencer.sv
// Directed bench for ace_snoop_sequencer: engine behaviour is played by hand-written stimulus.
module tb_ace_snoop_sequencer;

    localparam int AW = 44;
    localparam int DW = 128;
    localparam int LIM = 400;

    logic          ace_aclk = 1'b0;
    logic          ace_aresetn = 1'b0;
    logic          acvalid, acready, crvalid, crready, cdvalid, cdready, cdlast;
    logic [3:0]    acsnoop, o_snoop_state, o_acsnoop, i_devil_state;
    logic [AW-1:0] acaddr, o_acaddr;
    logic [4:0]    crresp, i_devil_crresp;
    logic [DW-1:0] cddata, i_devil_rdata;
    logic          i_devil_crvalid, i_devil_cdvalid, i_devil_cdlast, i_en;
    logic [15:0]   i_timeout;
    logic [31:0]   o_cnt_snoop, o_cnt_devil, o_cnt_default, o_cnt_timeout;

    ace_snoop_sequencer dut (
        .ace_aclk(ace_aclk), .ace_aresetn(ace_aresetn),
        .acvalid(acvalid), .acready(acready), .acsnoop(acsnoop), .acaddr(acaddr),
        .crvalid(crvalid), .crready(crready), .crresp(crresp),
        .cdvalid(cdvalid), .cdready(cdready), .cddata(cddata), .cdlast(cdlast),
        .o_snoop_state(o_snoop_state), .o_acsnoop(o_acsnoop), .o_acaddr(o_acaddr),
        .i_devil_state(i_devil_state), .i_devil_crvalid(i_devil_crvalid),
        .i_devil_cdvalid(i_devil_cdvalid), .i_devil_cdlast(i_devil_cdlast),
        .i_devil_crresp(i_devil_crresp), .i_devil_rdata(i_devil_rdata),
        .i_en(i_en), .i_timeout(i_timeout),
        .o_cnt_snoop(o_cnt_snoop), .o_cnt_devil(o_cnt_devil),
        .o_cnt_default(o_cnt_default), .o_cnt_timeout(o_cnt_timeout)
    );

    always #5 ace_aclk = ~ace_aclk;

    int cyc_n = 0;
    always @(posedge ace_aclk) cyc_n <= cyc_n + 1;

    int n_acr = 0, n_crv = 0, n_cdv = 0, n_cdhs = 0, n_cdl = 0, n_ss = 0, n_both = 0;
    always @(negedge ace_aclk) begin
        if (acready) n_acr++;
        if (crvalid) n_crv++;
        if (cdvalid) n_cdv++;
        if (cdvalid && cdready) n_cdhs++;
        if (cdvalid && cdready && cdlast) n_cdl++;
        if (o_snoop_state != 4'd0) n_ss++;
        if (crvalid && cdvalid) n_both++;
    end

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ace_aclk);
        #1;
    endtask

    function automatic logic [127:0] pat(input int b);
        logic [31:0] lo;
        lo = 32'hD000_0000 + 32'(b);
        return {96'h0123_4567_89AB_CDEF_0011_2233, lo};
    endfunction

    task automatic eng_idle();
        i_devil_state   = 4'd0;
        i_devil_crvalid = 1'b0;
        i_devil_cdvalid = 1'b0;
        i_devil_cdlast  = 1'b0;
        i_devil_crresp  = 5'd0;
        i_devil_rdata   = '0;
    endtask

    // Holds acvalid until acready; returns one cycle after the ack with acvalid dropped.
    task automatic start_snoop(input logic [3:0] snp, input logic [AW-1:0] addr, output int t_ack);
        acsnoop = snp;
        acaddr  = addr;
        acvalid = 1'b1;
        for (int i = 0; i < LIM && !acready; i++) cyc();
        chk("ack_seen", 128'(acready), 128'(1));
        t_ack = cyc_n;
        cyc();
        acvalid = 1'b0;
    endtask

    task automatic wait_crv(input string tag);
        for (int i = 0; i < LIM && !crvalid; i++) cyc();
        chk(tag, 128'(crvalid), 128'(1));
    endtask

    task automatic wait_cdv(input string tag);
        for (int i = 0; i < LIM && !cdvalid; i++) cyc();
        chk(tag, 128'(cdvalid), 128'(1));
    endtask

    // Engine keeps cdvalid high; data per beat is pat(beat). cdready assumed 1.
    task automatic do_beats(input string tag, input int last_delay, input int stop_at);
        int held;
        for (int b = 0; b < 4; b++) begin
            i_devil_rdata = pat(b);
            if (b == 3 && last_delay > 0) begin
                i_devil_cdlast = 1'b0;
                held = 0;
                for (int i = 0; i < last_delay; i++) begin
                    cyc();
                    if (cdvalid) held++;
                end
                chk($sformatf("%s_last_held", tag), 128'(held), 128'(0));
                i_devil_cdlast = 1'b1;
                cyc();
                chk($sformatf("%s_last_late", tag), 128'(cdvalid), 128'(1));
            end else begin
                i_devil_cdlast = (b == 3);
                wait_cdv($sformatf("%s_b%0d_seen", tag, b));
            end
            chk($sformatf("%s_b%0d_data", tag, b), cddata, pat(b));
            chk($sformatf("%s_b%0d_last", tag, b), 128'(cdlast), 128'(b == 3));
            if (b == stop_at) return;
            cyc();
        end
    endtask

    initial begin
        int t_ack, t0, s_acr, s_crv, s_cdv, s_cdhs, s_cdl, s_ss;
        acvalid = 1'b0; acsnoop = '0; acaddr = '0; crready = 1'b0; cdready = 1'b0;
        i_en = 1'b0; i_timeout = 16'd0;
        eng_idle();
        repeat (3) cyc();
        ace_aresetn = 1'b1;
        cyc();

        chk("rst_flags", 128'({acready, crvalid, cdvalid, cdlast}), 128'(0));
        chk("rst_snoop_state", 128'(o_snoop_state), 128'(0));
        chk("rst_counters", 128'({o_cnt_snoop, o_cnt_devil, o_cnt_default, o_cnt_timeout}), 128'(0));

        // disabled: default response, engine never triggered
        i_en = 1'b0;
        s_acr = n_acr; s_cdv = n_cdv; s_ss = n_ss;
        start_snoop(4'h1, 44'h123_4567_89AB, t_ack);
        chk("t1_acsnoop", 128'(o_acsnoop), 128'(4'h1));
        chk("t1_acaddr", 128'(o_acaddr), 128'(44'h123_4567_89AB));
        wait_crv("t1_crv_seen");
        chk("t1_crresp", 128'(crresp), 128'(0));
        crready = 1'b1; cyc(); crready = 1'b0;
        repeat (4) cyc();
        chk("t1_acready_pulses", 128'(n_acr - s_acr), 128'(1));
        chk("t1_no_cd", 128'(n_cdv - s_cdv), 128'(0));
        chk("t1_no_trigger", 128'(n_ss - s_ss), 128'(0));
        chk("t1_cnt_default", 128'(o_cnt_default), 128'(1));
        chk("t1_cnt_snoop", 128'(o_cnt_snoop), 128'(1));

        // engine goes busy then back to idle without responding
        i_en = 1'b1;
        s_ss = n_ss;
        start_snoop(4'h7, 44'h000_0000_1040, t_ack);
        i_devil_state = 4'd5;
        repeat (3) cyc();
        chk("t2_no_early_cr", 128'(crvalid), 128'(0));
        i_devil_state = 4'd0;
        t0 = cyc_n;
        wait_crv("t2_crv_seen");
        chk("t2_cr_latency", 128'(cyc_n - t0), 128'(1));
        chk("t2_crresp", 128'(crresp), 128'(0));
        crready = 1'b1; cyc(); crready = 1'b0;
        repeat (4) cyc();
        chk("t2_trigger_pulse", 128'(n_ss - s_ss), 128'(1));
        chk("t2_cnt_default", 128'(o_cnt_default), 128'(2));
        chk("t2_cnt_devil", 128'(o_cnt_devil), 128'(0));

        // engine response with data, crready delayed 3 cycles
        s_crv = n_crv; s_cdhs = n_cdhs; s_cdl = n_cdl;
        start_snoop(4'hB, 44'h0AB_CDEF_0000, t_ack);
        i_devil_state = 4'd3; i_devil_crvalid = 1'b1; i_devil_crresp = 5'b00001;
        wait_crv("t3_crv_seen");
        chk("t3_crresp", 128'(crresp), 128'(5'b00001));
        repeat (3) cyc();
        crready = 1'b1; cdready = 1'b1; i_devil_cdvalid = 1'b1;
        cyc();
        crready = 1'b0;
        do_beats("t3", 0, -1);
        eng_idle();
        repeat (4) cyc();
        chk("t3_crvalid_cycles", 128'(n_crv - s_crv), 128'(4));
        chk("t3_cd_beats", 128'(n_cdhs - s_cdhs), 128'(4));
        chk("t3_cdlast_count", 128'(n_cdl - s_cdl), 128'(1));
        chk("t3_cnt_devil", 128'(o_cnt_devil), 128'(1));

        // engine cdlast 150 cycles late stretches the final beat
        s_cdhs = n_cdhs; s_cdl = n_cdl;
        start_snoop(4'hB, 44'h0AB_CDEF_0040, t_ack);
        i_devil_state = 4'd3; i_devil_crvalid = 1'b1; i_devil_crresp = 5'b00001;
        wait_crv("t4_crv_seen");
        crready = 1'b1; i_devil_cdvalid = 1'b1;
        cyc();
        crready = 1'b0;
        do_beats("t4", 150, -1);
        eng_idle();
        repeat (4) cyc();
        chk("t4_cd_beats", 128'(n_cdhs - s_cdhs), 128'(4));
        chk("t4_cdlast_count", 128'(n_cdl - s_cdl), 128'(1));
        chk("t4_cnt_devil", 128'(o_cnt_devil), 128'(2));

        // engine stuck: timeout to default CR, RELEASE bounded by the same timeout
        i_timeout = 16'd20;
        start_snoop(4'h2, 44'h000_0000_2000, t_ack);
        i_devil_state = 4'd6;
        wait_crv("t5_crv_seen");
        chk("t5_timeout_latency", 128'(cyc_n - t_ack), 128'(21));
        chk("t5_crresp", 128'(crresp), 128'(0));
        chk("t5_cnt_timeout", 128'(o_cnt_timeout), 128'(1));
        crready = 1'b1;
        t0 = cyc_n;
        cyc();
        crready = 1'b0;
        acsnoop = 4'h3; acaddr = 44'h000_0000_3000; acvalid = 1'b1;
        for (int i = 0; i < LIM && !acready; i++) cyc();
        chk("t5_release_exit", 128'(cyc_n - t0), 128'(22));
        t_ack = cyc_n;
        cyc();
        acvalid = 1'b0;
        i_devil_state = 4'd0;
        wait_crv("t5b_crv_seen");
        chk("t5b_timeout_latency", 128'(cyc_n - t_ack), 128'(21));
        crready = 1'b1; cyc(); crready = 1'b0;
        repeat (4) cyc();
        chk("t5_cnt_timeout2", 128'(o_cnt_timeout), 128'(2));
        chk("t5_cnt_default", 128'(o_cnt_default), 128'(4));
        chk("t5_cnt_snoop", 128'(o_cnt_snoop), 128'(6));
        chk("no_cr_cd_overlap", 128'(n_both), 128'(0));

        // reset during DEV_CD beat 2
        i_timeout = 16'd0;
        start_snoop(4'hB, 44'h0AB_CDEF_0080, t_ack);
        i_devil_state = 4'd3; i_devil_crvalid = 1'b1; i_devil_crresp = 5'b00001;
        wait_crv("t6_crv_seen");
        crready = 1'b1; i_devil_cdvalid = 1'b1;
        cyc();
        crready = 1'b0;
        do_beats("t6", 0, 2);
        #1 ace_aresetn = 1'b0;
        #1;
        chk("t6_rst_flags", 128'({acready, crvalid, cdvalid, cdlast}), 128'(0));
        chk("t6_rst_payload", cddata | 128'(crresp) | 128'(o_acaddr) | 128'(o_snoop_state), 128'(0));
        chk("t6_rst_counters", 128'({o_cnt_snoop, o_cnt_devil, o_cnt_default, o_cnt_timeout}), 128'(0));
        eng_idle();
        cdready = 1'b0;
        repeat (2) cyc();
        ace_aresetn = 1'b1;
        cyc();
        s_cdv = n_cdv;
        start_snoop(4'h5, 44'h000_0000_5000, t_ack);
        i_devil_state = 4'd3; i_devil_crvalid = 1'b1; i_devil_crresp = 5'b00010;
        wait_crv("t6b_crv_seen");
        chk("t6b_crresp", 128'(crresp), 128'(5'b00010));
        crready = 1'b1; cyc(); crready = 1'b0;
        eng_idle();
        repeat (4) cyc();
        chk("t6b_no_cd", 128'(n_cdv - s_cdv), 128'(0));
        chk("t6b_cnt_snoop", 128'(o_cnt_snoop), 128'(1));
        chk("t6b_cnt_devil", 128'(o_cnt_devil), 128'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
